multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the shared datapath of the multicycle RISC-V core: a single ALU, memory port, IR, PC and register file.
- Decodes IR opcode and issues the 3-bit ALU_Op consumed by the ALU control decoder. Also issues mux selects and write strobes.
- Stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RISC-V core. It drives the shared ALU, memory, IR, PC and
// register-file datapath, stalls on the memory ready handshake and counts retired instructions.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic [2:0]           ALU_Op_o,
  output logic [1:0]           ALU_SrcA_o,
  output logic [1:0]           ALU_SrcB_o,
  output logic [1:0]           Result_Src_o,
  output logic                 IorD_o,
  output logic                 Mem_Read_o,
  output logic                 Mem_Write_o,
  output logic                 IR_Write_o,
  output logic                 PC_Write_o,
  output logic                 Reg_Write_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_o,
  output logic [3:0]           state_o
);

  localparam logic [3:0] RESET_S   = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] MEM_ADDR  = 4'd3;
  localparam logic [3:0] MEM_READ  = 4'd4;
  localparam logic [3:0] MEM_WB    = 4'd5;
  localparam logic [3:0] MEM_WRITE = 4'd6;
  localparam logic [3:0] EXEC_R    = 4'd7;
  localparam logic [3:0] EXEC_I    = 4'd8;
  localparam logic [3:0] ALU_WB    = 4'd9;
  localparam logic [3:0] EXEC_LUI  = 4'd10;
  localparam logic [3:0] BEQ       = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 retire_s;

  // Next-state and control decode; FETCH/BEQ strobes depend on inputs in the same cycle
  always_comb begin
    state_d      = state_q;
    retire_s     = 1'b0;
    ALU_Op_o     = 3'b000;
    ALU_SrcA_o   = 2'b00;
    ALU_SrcB_o   = 2'b00;
    Result_Src_o = 2'b00;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    IR_Write_o   = 1'b0;
    PC_Write_o   = 1'b0;
    Reg_Write_o  = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        Mem_Read_o   = 1'b1;
        ALU_SrcB_o   = 2'b10;
        ALU_Op_o     = 3'b110;
        Result_Src_o = 2'b10;
        if (mem_ready_i) begin
          IR_Write_o = 1'b1;
          PC_Write_o = 1'b1;
          state_d    = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        // ALU computes the branch target here so BEQ can pick it up from ALUOut
        ALU_SrcA_o = 2'b01;
        ALU_SrcB_o = 2'b01;
        ALU_Op_o   = 3'b110;
        case (opcode_i)
          OP_R:     state_d = EXEC_R;
          OP_I:     state_d = EXEC_I;
          OP_LUI:   state_d = EXEC_LUI;
          OP_BEQ:   state_d = BEQ;
          OP_LOAD:  state_d = MEM_ADDR;
          OP_STORE: state_d = MEM_ADDR;
          default: begin
            illegal_o = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        ALU_SrcA_o = 2'b10;
        state_d    = ALU_WB;
      end
      EXEC_I: begin
        ALU_SrcA_o = 2'b10;
        ALU_SrcB_o = 2'b01;
        ALU_Op_o   = 3'b001;
        state_d    = ALU_WB;
      end
      EXEC_LUI: begin
        ALU_SrcB_o = 2'b01;
        ALU_Op_o   = 3'b100;
        state_d    = ALU_WB;
      end
      ALU_WB: begin
        Reg_Write_o = 1'b1;
        retire_s    = 1'b1;
        state_d     = FETCH;
      end
      MEM_ADDR: begin
        ALU_SrcA_o = 2'b10;
        ALU_SrcB_o = 2'b01;
        ALU_Op_o   = 3'b110;
        if (opcode_i == OP_LOAD) begin
          state_d = MEM_READ;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      MEM_READ: begin
        Mem_Read_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = MEM_WB;
        end else begin
          state_d = MEM_READ;
        end
      end
      MEM_WB: begin
        Result_Src_o = 2'b01;
        Reg_Write_o  = 1'b1;
        retire_s     = 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        Mem_Write_o = 1'b1;
        IorD_o      = 1'b1;
        if (mem_ready_i) begin
          retire_s = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      BEQ: begin
        ALU_SrcA_o = 2'b10;
        ALU_Op_o   = 3'b101;
        PC_Write_o = zero_i;
        retire_s   = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = RESET_S;
    endcase
  end

  // Retired-instruction counter, wraps naturally at its width
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RESET_S;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction-class model pushes the expected
// per-cycle state/control/counter record; a negedge monitor pops and compares.
module tb_multicycle_control;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode_i = 7'd0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic [2:0]    ALU_Op_o;
  logic [1:0]    ALU_SrcA_o, ALU_SrcB_o, Result_Src_o;
  logic          IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, PC_Write_o, Reg_Write_o, illegal_o;
  logic [CW-1:0] retired_o;
  logic [3:0]    state_o;

  multicycle_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .ALU_Op_o(ALU_Op_o), .ALU_SrcA_o(ALU_SrcA_o), .ALU_SrcB_o(ALU_SrcB_o),
    .Result_Src_o(Result_Src_o), .IorD_o(IorD_o), .Mem_Read_o(Mem_Read_o),
    .Mem_Write_o(Mem_Write_o), .IR_Write_o(IR_Write_o), .PC_Write_o(PC_Write_o),
    .Reg_Write_o(Reg_Write_o), .illegal_o(illegal_o), .retired_o(retired_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [15:0]   ctrl;
    logic [CW-1:0] ret;
  } rec_t;

  rec_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned ret_m = 0;

  localparam int C_R = 0, C_I = 1, C_LUI = 2, C_BEQ = 3, C_LW = 4, C_SW = 5, C_ILL = 6;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] r, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic pcw,
                                     input logic rw, input logic ill);
    return {op, a, b, r, iord, mr, mw, irw, pcw, rw, ill};
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LUI:   return 7'b0110111;
      C_BEQ:   return 7'b1100011;
      C_LW:    return 7'b0000011;
      default: return 7'b0100011;
    endcase
  endfunction

  function automatic logic [15:0] act_ctrl();
    return {ALU_Op_o, ALU_SrcA_o, ALU_SrcB_o, Result_Src_o, IorD_o, Mem_Read_o, Mem_Write_o,
            IR_Write_o, PC_Write_o, Reg_Write_o, illegal_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus its expected observation
  task automatic cyc(input logic [6:0] opc, input logic [3:0] st, input logic rdy, input logic z,
                     input logic [15:0] c, input logic ret);
    @(posedge clk);
    #1;
    opcode_i    = opc;
    mem_ready_i = rdy;
    zero_i      = z;
    q.push_back(rec_t'{st, c, CW'(ret_m)});
    if (ret) ret_m = (ret_m + 1) % (1 << CW);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input int cls, input logic [6:0] opc, input int fw, input int mw,
                           input logic z, input logic abort);
    logic [15:0] wb;
    wb = mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < fw; i++)
      cyc(opc, 4'd1, 1'b0, rb(), mk(3'b110, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    cyc(opc, 4'd1, 1'b1, rb(), mk(3'b110, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    cyc(opc, 4'd2, rb(), rb(), mk(3'b110, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  (cls == C_ILL) ? 1'b1 : 1'b0), 1'b0);
    case (cls)
      C_R: begin
        cyc(opc, 4'd7, rb(), rb(), mk(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(opc, 4'd9, rb(), rb(), wb, 1'b1);
      end
      C_I: begin
        cyc(opc, 4'd8, rb(), rb(), mk(3'b001, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(opc, 4'd9, rb(), rb(), wb, 1'b1);
      end
      C_LUI: begin
        cyc(opc, 4'd10, rb(), rb(), mk(3'b100, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(opc, 4'd9, rb(), rb(), wb, 1'b1);
      end
      C_BEQ:
        cyc(opc, 4'd11, rb(), z, mk(3'b101, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0), 1'b1);
      C_LW: begin
        cyc(opc, 4'd3, rb(), rb(), mk(3'b110, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < mw; i++)
          cyc(opc, 4'd4, 1'b0, rb(), mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(opc, 4'd4, 1'b1, rb(), mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(opc, 4'd5, rb(), rb(), mk(3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      end
      C_SW: begin
        cyc(opc, 4'd3, rb(), rb(), mk(3'b110, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < mw; i++)
          cyc(opc, 4'd6, 1'b0, rb(), mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        if (!abort)
          cyc(opc, 4'd6, 1'b1, rb(), mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      end
      default: ;
    endcase
  endtask

  // Scoreboard monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    rec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(state_o), 32'(e.st));
      chk("ctrl", 32'(act_ctrl()), 32'(e.ctrl));
      chk("retired", 32'(retired_o), 32'(e.ret));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  logic [6:0] ill_ops [4];

  initial begin
    int cls;
    ill_ops[0] = 7'b1111111;
    ill_ops[1] = 7'b0000000;
    ill_ops[2] = 7'b1101111;
    ill_ops[3] = 7'b0010111;
    #12;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_ctrl", 32'(act_ctrl()), 32'd0);
    chk("reset_retired", 32'(retired_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.push_back(rec_t'{4'd0, 16'd0, CW'(ret_m)});

    run_instr(C_R, op_of(C_R), 0, 0, 1'b0, 1'b0);
    run_instr(C_LW, op_of(C_LW), 2, 2, 1'b0, 1'b0);
    run_instr(C_BEQ, op_of(C_BEQ), 0, 0, 1'b1, 1'b0);
    run_instr(C_BEQ, op_of(C_BEQ), 0, 0, 1'b0, 1'b0);
    run_instr(C_ILL, 7'b1111111, 0, 0, 1'b0, 1'b0);
    run_instr(C_SW, op_of(C_SW), 1, 1, 1'b0, 1'b0);
    run_instr(C_LUI, op_of(C_LUI), 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 6));
      if (cls == C_ILL)
        run_instr(cls, ill_ops[$urandom_range(0, 3)], int'($urandom_range(0, 2)), 0, 1'b0, 1'b0);
      else
        run_instr(cls, op_of(cls), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb(), 1'b0);
    end

    // Store caught mid-write by reset
    run_instr(C_SW, op_of(C_SW), 0, 1, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    mem_ready_i = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_memwrite", 32'(Mem_Write_o), 32'd0);
    chk("rst_mid_ctrl", 32'(act_ctrl()), 32'd0);
    chk("rst_mid_retired", 32'(retired_o), 32'd0);
    ret_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.push_back(rec_t'{4'd0, 16'd0, CW'(ret_m)});

    // Counter wrap: 15 ADDIs to reach all-ones, one more wraps to zero
    for (int n = 0; n < 16; n++)
      run_instr(C_I, op_of(C_I), 0, 0, 1'b0, 1'b0);
    cyc(7'b0000000, 4'd1, 1'b0, 1'b0,
        mk(3'b110, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    #1;
    chk("wrap_retired", 32'(retired_o), 32'd0);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
